// File: rtl/bcd_binaris.sv
// Sequential BCD-to-binary converter: accumulates packed BCD digits MSD-first,
// one digit per clock, with a start/ready/hiba handshake.
module bcd_binaris #(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned BITS   = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_be,
    output logic [BITS-1:0]       eredmeny,
    output logic                  ready,
    output logic                  hiba
);

    localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned NW = BITS + 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [4*DIGITS-1:0]   r_shadow;
    logic [BITS-1:0]       r_acc;
    logic [CW-1:0]         r_cnt;
    logic                  r_err;
    logic [BITS-1:0]       r_eredmeny;
    logic                  r_ready;
    logic                  r_hiba;

    state_t                w_state_nxt;
    logic [4*DIGITS-1:0]   w_shadow_nxt;
    logic [BITS-1:0]       w_acc_nxt;
    logic [CW-1:0]         w_cnt_nxt;
    logic                  w_err_nxt;
    logic [BITS-1:0]       w_eredmeny_nxt;
    logic                  w_ready_nxt;
    logic                  w_hiba_nxt;

    logic [3:0]            w_digit;
    logic [NW-1:0]         w_acc_ext;
    logic [NW-1:0]         w_next;
    logic                  w_err_step;

    // Current digit mux and one multiply-accumulate step (acc*10 + d).
    always_comb begin
        w_digit = 4'd0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (r_cnt == CW'(i)) begin
                w_digit = r_shadow[4*i +: 4];
            end
        end
        w_acc_ext  = NW'(r_acc);
        w_next     = (w_acc_ext << 3) + (w_acc_ext << 1) + NW'(w_digit);
        w_err_step = r_err | (w_digit > 4'd9) | (|w_next[NW-1:BITS]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shadow   <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_eredmeny <= '0;
            r_ready    <= 1'b0;
            r_hiba     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shadow   <= w_shadow_nxt;
            r_acc      <= w_acc_nxt;
            r_cnt      <= w_cnt_nxt;
            r_err      <= w_err_nxt;
            r_eredmeny <= w_eredmeny_nxt;
            r_ready    <= w_ready_nxt;
            r_hiba     <= w_hiba_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_shadow_nxt   = r_shadow;
        w_acc_nxt      = r_acc;
        w_cnt_nxt      = r_cnt;
        w_err_nxt      = r_err;
        w_eredmeny_nxt = r_eredmeny;
        w_ready_nxt    = 1'b0;
        w_hiba_nxt     = r_hiba;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_shadow_nxt = bcd_be;
                    w_acc_nxt    = '0;
                    w_err_nxt    = 1'b0;
                    w_cnt_nxt    = CW'(DIGITS - 1);
                    w_state_nxt  = CONV;
                end
            end
            CONV: begin
                w_acc_nxt = w_next[BITS-1:0];
                w_err_nxt = w_err_step;
                if (r_cnt == '0) begin
                    // Publish the result, folding in an error on the last digit.
                    w_state_nxt    = DONE;
                    w_ready_nxt    = 1'b1;
                    w_hiba_nxt     = w_err_step;
                    w_eredmeny_nxt = w_err_step ? '1 : w_next[BITS-1:0];
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign eredmeny = r_eredmeny;
    assign ready    = r_ready;
    assign hiba     = r_hiba;

endmodule

// File: tb/tb_bcd_binaris.sv
// Self-checking bench for bcd_binaris: a timeline/arithmetic model checked every
// cycle on two instances (BITS=10 and BITS=8), plus directed literal checks.
module tb_bcd_binaris;

    localparam int DIGITS = 3;

    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] bcd_be;
    logic [9:0]  eredmeny;
    logic        ready;
    logic        hiba;
    logic [7:0]  eredmeny8;
    logic        ready8;
    logic        hiba8;

    int n_cmp;
    int n_bad;

    bcd_binaris #(.DIGITS(3), .BITS(10)) dut (
        .clk(clk), .rst(rst), .start(start), .bcd_be(bcd_be),
        .eredmeny(eredmeny), .ready(ready), .hiba(hiba)
    );

    bcd_binaris #(.DIGITS(3), .BITS(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .bcd_be(bcd_be),
        .eredmeny(eredmeny8), .ready(ready8), .hiba(hiba8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal value of the BCD word and whether it is representable in 'bits'.
    function automatic bit conv_err(input logic [11:0] v, input int bits);
        int val;
        int d;
        bit bad;
        val = 0;
        bad = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = (int'(v) >> (4 * i)) & 15;
            if (d > 9) bad = 1'b1;
            val = val * 10 + d;
        end
        return bad || (val >= (1 << bits));
    endfunction

    function automatic int conv_res(input logic [11:0] v, input int bits);
        int val;
        val = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            val = val * 10 + ((int'(v) >> (4 * i)) & 15);
        end
        return conv_err(v, bits) ? ((1 << bits) - 1) : val;
    endfunction

    // Model: a conversion occupies DIGITS edges, then one ready cycle, then idle.
    int          m_left;
    bit          m_busy;
    logic [11:0] m_val;
    logic        exp_ready;
    logic [9:0]  exp_e10;
    logic        exp_h10;
    logic [7:0]  exp_e8;
    logic        exp_h8;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left    <= 0;
            m_busy    <= 1'b0;
            m_val     <= '0;
            exp_ready <= 1'b0;
            exp_e10   <= '0;
            exp_h10   <= 1'b0;
            exp_e8    <= '0;
            exp_h8    <= 1'b0;
        end else begin
            exp_ready <= 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_busy <= 1'b1;
                    m_left <= DIGITS;
                    m_val  <= bcd_be;
                end
            end else if (m_left > 1) begin
                m_left <= m_left - 1;
            end else if (m_left == 1) begin
                m_left    <= 0;
                exp_ready <= 1'b1;
                exp_e10   <= 10'(conv_res(m_val, 10));
                exp_h10   <= conv_err(m_val, 10);
                exp_e8    <= 8'(conv_res(m_val, 8));
                exp_h8    <= conv_err(m_val, 8);
            end else begin
                m_busy <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pulse start for one cycle with value v; checks latency and literal results.
    task automatic convert(input logic [11:0] v, input logic [9:0] e10, input logic h10,
                           input logic [7:0] e8, input logic h8);
        int n;
        @(posedge clk); #1;
        bcd_be = v;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (ready) begin
                n = i;
                break;
            end
        end
        chk("latency", 32'(n), 32'(DIGITS));
        chk("lit_eredmeny", 32'(eredmeny), 32'(e10));
        chk("lit_hiba", 32'(hiba), 32'(h10));
        chk("lit_eredmeny8", 32'(eredmeny8), 32'(e8));
        chk("lit_hiba8", 32'(hiba8), 32'(h8));
        @(posedge clk); #1;
        chk("ready_one_cycle", 32'(ready), 32'd0);
    endtask

    initial begin
        int n;
        n_cmp  = 0;
        n_bad  = 0;
        rst    = 1'b1;
        start  = 1'b0;
        bcd_be = '0;

        fork
            forever begin
                @(negedge clk);
                chk("ready", 32'(ready), 32'(exp_ready));
                chk("eredmeny", 32'(eredmeny), 32'(exp_e10));
                chk("hiba", 32'(hiba), 32'(exp_h10));
                chk("ready8", 32'(ready8), 32'(exp_ready));
                chk("eredmeny8", 32'(eredmeny8), 32'(exp_e8));
                chk("hiba8", 32'(hiba8), 32'(exp_h8));
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_eredmeny", 32'(eredmeny), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_hiba", 32'(hiba), 32'd0);
        rst = 1'b0;

        convert(12'h999, 10'd999, 1'b0, 8'hFF, 1'b1);
        convert(12'h000, 10'd0,   1'b0, 8'd0,  1'b0);
        convert(12'h105, 10'd105, 1'b0, 8'd105, 1'b0);
        convert(12'h1A3, 10'h3FF, 1'b1, 8'hFF, 1'b1);
        convert(12'h042, 10'd42,  1'b0, 8'd42, 1'b0);
        convert(12'h255, 10'd255, 1'b0, 8'd255, 1'b0);
        convert(12'h256, 10'd256, 1'b0, 8'hFF, 1'b1);
        convert(12'hF09, 10'h3FF, 1'b1, 8'hFF, 1'b1);

        // Start held high; input changes after sampling must not leak in.
        @(posedge clk); #1;
        bcd_be = 12'h123;
        start  = 1'b1;
        @(posedge clk); #1;
        bcd_be = 12'h777;
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (ready) begin
                n = i;
                break;
            end
        end
        chk("held_latency", 32'(n), 32'(DIGITS));
        chk("held_first", 32'(eredmeny), 32'd123);
        chk("held_first8", 32'(eredmeny8), 32'd123);
        n = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (ready) begin
                n = i;
                break;
            end
        end
        start = 1'b0;
        chk("held_period", 32'(n), 32'(DIGITS + 2));
        chk("held_second", 32'(eredmeny), 32'd777);
        chk("held_second_hiba8", 32'(hiba8), 32'd1);
        repeat (2) @(posedge clk);

        // Asynchronous reset in the middle of a conversion.
        @(posedge clk); #1;
        bcd_be = 12'h999;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        chk("pre_rst_eredmeny", 32'(eredmeny), 32'd777);
        rst = 1'b1;
        #1;
        chk("async_rst_eredmeny", 32'(eredmeny), 32'd0);
        chk("async_rst_ready", 32'(ready), 32'd0);
        chk("async_rst_hiba8", 32'(hiba8), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ready) n++;
        end
        chk("no_ready_after_abort", 32'(n), 32'd0);
        convert(12'h064, 10'd64, 1'b0, 8'd64, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_binaris.md
Name: bcd_binaris

Overview:
Sequential BCD-to-binary converter. It is the inverse of the calculator's binary-to-BCD path (divide by 100, then divide by 10). It takes DIGITS packed BCD digits, for example from DIP switches or a keypad front-end, and accumulates them MSD-first as acc = acc*10 + digit, one digit per clock. It uses the same start/ready/hiba handshake as the team's divider, so it can feed the arithmetic datapath directly.

Parameters:
DIGITS, 3, number of BCD digits in bcd_be; minimum 1.
BITS, 10, width of the binary result eredmeny; 10 covers 999.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  conversion request; sampled only in IDLE.
bcd_be  input  4*DIGITS  packed BCD; digit i occupies [4i+3:4i]; digit DIGITS-1 is the MSD.
eredmeny  output  BITS  binary result; holds its value until the next completion.
ready  output  1  one-cycle completion pulse.
hiba  output  1  error flag (invalid BCD digit or overflow); valid while ready=1 and held until the next completion.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, acc=0, cnt=0.
  - eredmeny=0, ready=0, hiba=0, internal error flag=0.
- States: IDLE, CONV, DONE. All outputs are registered.
- IDLE:
  - On a clock edge with start=1: latch bcd_be into a shadow register, clear acc, clear the error flag, set cnt=DIGITS-1, go to CONV.
  - With start=0: stay in IDLE.
- CONV, one edge per digit; d = shadow digit[cnt]:
  - If d>9, set the error flag (sticky for this conversion).
  - Compute next = acc*10 + d in BITS+4 bits, using (acc<<3)+(acc<<1)+d.
  - If next >= 2^BITS, set the error flag. acc <= next truncated to BITS.
  - If cnt==0 go to DONE; otherwise cnt <= cnt-1.
- Entering DONE (same edge as the last CONV step):
  - ready <= 1.
  - hiba <= error flag, including any error detected on the last digit.
  - eredmeny <= all ones if error, else the final acc.
- DONE: next edge ready <= 0 and state goes to IDLE, unconditionally.
- Latency: start sampled at edge E0 gives ready=1 in the cycle after edge E0+DIGITS, for exactly 1 cycle.
- Throughput: with start held high, a new conversion starts at edge E0+DIGITS+2, so one result every DIGITS+2 cycles.
- start during CONV or DONE is ignored, not queued.
- bcd_be changes after the sampling edge do not affect the running conversion.
- A digit value of 0xA–0xF never stops the conversion; it only forces the error result.
- Reset mid-conversion aborts immediately:
  - No ready pulse is produced.
  - eredmeny returns to 0.
  - The first edge after reset release with start=1 begins a fresh conversion.
- eredmeny and hiba change only on the DONE-entry edge or on reset.

Test Plan:
1. Default params, bcd_be=0x999, start pulsed for 1 cycle -> ready for exactly 1 cycle, 3 edges after sampling; eredmeny=999 (0x3E7), hiba=0.
2. bcd_be=0x000 -> eredmeny=0, hiba=0. Then bcd_be=0x105 -> eredmeny=105.
3. bcd_be=0x1A3 (invalid middle digit) -> hiba=1, eredmeny=0x3FF. A following 0x042 -> hiba=0, eredmeny=42.
4. BITS=8: bcd_be=0x255 -> eredmeny=255, hiba=0. bcd_be=0x256 -> hiba=1, eredmeny=0xFF.
5. start held high, bcd_be changed to 0x777 one cycle after sampling 0x123 -> first result 123, next result 777. Ready pulses exactly 5 cycles apart, with no pulse in between.
6. rst asserted asynchronously in the middle of CONV -> outputs 0 immediately, no ready pulse. After release, bcd_be=0x064 with start -> eredmeny=64.
